// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: two-master round-robin Wishbone arbiter, grant locked for the whole cyc.
// Define WISHBONE_ARBITER_TIMEOUT_EN to compile in the watchdog (counter, ABORT state, err pulses).
module wishbone_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_addr_i,
    input  logic [63:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [63:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_addr_i,
    input  logic [63:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [63:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_addr_o,
    output logic [63:0] s_data_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [63:0] s_data_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt;
    logic       err0;
    logic       err1;
    assign m0_err_o = err0;
    assign m1_err_o = err1;
`else
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif
    state_t state;
    logic   last;
    logic   own;
    logic   g0;
    logic   g1;
    logic   own_cyc;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_range
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    assign g0      = state == GNT0;
    assign g1      = state == GNT1;
    assign own_cyc = own ? m1_cyc_i : m0_cyc_i;

    // Slave side is a pure combinational mux of the granted master; idle/abort drive zeros.
    assign s_addr_o  = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
    assign s_data_o  = g0 ? m0_data_i : g1 ? m1_data_i : '0;
    assign s_we_o    = g0 ? m0_we_i   : g1 ? m1_we_i   : 1'b0;
    assign s_cyc_o   = g0 ? m0_cyc_i  : g1 ? m1_cyc_i  : 1'b0;
    assign s_stb_o   = g0 ? m0_stb_i  : g1 ? m1_stb_i  : 1'b0;
    assign m0_data_o = g0 ? s_data_i : '0;
    assign m1_data_o = g1 ? s_data_i : '0;
    assign m0_ack_o  = g0 & s_ack_i;
    assign m1_ack_o  = g1 & s_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            own   <= 1'b0;
            gnt_o <= '0;
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
            cnt   <= '0;
            err0  <= 1'b0;
            err1  <= 1'b0;
`endif
        end else begin
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
            err0 <= 1'b0;
            err1 <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
                    cnt <= '0;
`endif
                    // On a tie the master that was not served last wins.
                    if (m0_cyc_i && (last || !m1_cyc_i)) begin
                        state <= GNT0;
                        own   <= 1'b0;
                        gnt_o <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        own   <= 1'b1;
                        gnt_o <= 2'b10;
                    end
                end
                default: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                        last  <= own;
                        gnt_o <= '0;
                    end
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
                    else if (state != ABORT) begin
                        if (s_ack_i)
                            cnt <= '0;
                        else if (s_stb_o) begin
                            if (cnt == LIMIT) begin
                                state <= ABORT;
                                gnt_o <= '0;
                                err0  <= !own;
                                err1  <= own;
                                cnt   <= '0;
                            end else
                                cnt <= cnt + 8'd1;
                        end
                    end
`endif
                end
            endcase
        end
    end
endmodule
